uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: 2-flop synchronizer, 16x-oversampled FSM, held byte with ack/overrun.
// Latency: 8+16*(DATA_BITS+1) ticks after the start edge is seen; the held byte waits for rx_ack.
module uart_rx #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t                 state, state_n;
  logic [3:0]             cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [DATA_BITS-1:0]   shreg, shreg_n;
  logic                   rx_meta, rx_s;
  logic                   deliver, ferr, ack;
  logic                   valid_n, overrun_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= ST_IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      rx_valid  <= valid_n;
      overrun   <= overrun_n;
      frame_err <= ferr;
      if (deliver) rx_data <= shreg;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    deliver = 1'b0;
    ferr    = 1'b0;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            cnt_n   = '0;
          end
        end
        ST_START: begin
          // mid start bit: a high line here was only a glitch
          if (cnt == 4'd7) begin
            cnt_n = '0;
            idx_n = '0;
            state_n = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
        ST_DATA: begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
            if (idx == IW'(DATA_BITS - 1)) begin
              state_n = ST_STOP;
            end else begin
              idx_n = idx + IW'(1);
            end
          end
        end
        ST_STOP: begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'd15) begin
            if (rx_s) begin
              deliver = 1'b1;
              state_n = ST_IDLE;
            end else begin
              ferr    = 1'b1;
              state_n = ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          if (rx_s) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // an ack landing with a new byte clears overrun but keeps the new byte valid
  always_comb begin
    ack       = rx_ack & rx_valid;
    valid_n   = deliver | (rx_valid & ~ack);
    overrun_n = (overrun & ~ack) | (deliver & rx_valid & ~rx_ack);
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of good frames plus hand sequences for glitch, break, overrun, reset.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick = 1'b0;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, overrun, frame_err, busy;

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int tick_div = 16;
  int tcnt = 0;

  uart_rx #(.DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx), .rx_ack(rx_ack),
    .rx_data(rx_data), .rx_valid(rx_valid), .overrun(overrun),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    tick = (tcnt == 0);
    tcnt = (tcnt >= tick_div - 1) ? 0 : tcnt + 1;
  end

  always @(negedge clk) if (frame_err) fe_cnt++;

  typedef struct {
    logic [7:0] dat;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(posedge clk);
      if (tick) c++;
    end
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop;
    wait_ticks(16);
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(posedge clk);
    #1 rx_ack = 1'b0;
  endtask

  // sends d starting just after a tick edge and counts clk edges until rx_valid rises
  task automatic send_timed(input logic [7:0] d, input int exp_edges);
    int n = 0;
    int fe0;
    wait_ticks(1);
    fe0 = fe_cnt;
    fork
      send_frame(d, 1'b1);
      begin
        do begin
          @(posedge clk);
          #1 n++;
        end while (!rx_valid && n < 5000);
      end
    join
    check("latency", n, exp_edges);
    check("timed_data", rx_data, d);
    check("timed_valid", rx_valid, 1'b1);
    check("timed_busy", busy, 1'b0);
    check("timed_no_ferr", fe_cnt - fe0, 0);
  endtask

  // abandons a frame during bit 3, then receives 0x5A cleanly
  task automatic reset_mid_frame();
    logic [7:0] d = 8'hC3;
    int fe0 = fe_cnt;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = d[3];
    wait_ticks(8);
    rst_n = 1'b0;
    rx = 1'b1;
    #1;
    check("rst_data", rx_data, 8'h00);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ticks(4);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_valid", rx_valid, 1'b0);
    send_frame(8'h5A, 1'b1);
    check("resync_data", rx_data, 8'h5A);
    check("resync_valid", rx_valid, 1'b1);
    check("resync_no_ferr", fe_cnt - fe0, 0);
  endtask

  initial begin
    int fe0;
    vecs[0] = '{dat: 8'h00, exp_data: 8'h00, exp_valid: 1'b1};
    vecs[1] = '{dat: 8'hFF, exp_data: 8'hFF, exp_valid: 1'b1};
    vecs[2] = '{dat: 8'h01, exp_data: 8'h01, exp_valid: 1'b1};
    vecs[3] = '{dat: 8'h5A, exp_data: 8'h5A, exp_valid: 1'b1};
    vecs[4] = '{dat: 8'h80, exp_data: 8'h80, exp_valid: 1'b1};

    rst_n = 1'b0;
    rx = 1'b1;
    rx_ack = 1'b0;
    #1;
    check("reset_data", rx_data, 8'h00);
    check("reset_valid", rx_valid, 1'b0);
    check("reset_overrun", overrun, 1'b0);
    check("reset_ferr", frame_err, 1'b0);
    check("reset_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // 0xA5 with exact timing: detect at first tick (16 clk), valid 152 ticks later
    send_timed(8'hA5, 16 + 152 * 16);
    pulse_ack();
    check("ack_clears_valid", rx_valid, 1'b0);

    for (int i = 0; i < 5; i++) begin
      fe0 = fe_cnt;
      wait_ticks(1);
      send_frame(vecs[i].dat, 1'b1);
      check("vec_data", rx_data, vecs[i].exp_data);
      check("vec_valid", rx_valid, vecs[i].exp_valid);
      check("vec_overrun", overrun, 1'b0);
      check("vec_busy", busy, 1'b0);
      check("vec_no_ferr", fe_cnt - fe0, 0);
      pulse_ack();
      check("vec_ack", rx_valid, 1'b0);
    end

    // short low pulse is rejected at mid start bit
    fe0 = fe_cnt;
    wait_ticks(1);
    rx = 1'b0;
    wait_ticks(2);
    check("glitch_busy_hi", busy, 1'b1);
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(6);
    check("glitch_busy_lo", busy, 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_no_ferr", fe_cnt - fe0, 0);

    // bad stop bit followed by a held break
    fe0 = fe_cnt;
    wait_ticks(1);
    send_frame(8'h3C, 1'b0);
    wait_ticks(48);
    check("break_ferr_once", fe_cnt - fe0, 1);
    check("break_valid", rx_valid, 1'b0);
    check("break_data_kept", rx_data, 8'h80);
    check("break_busy", busy, 1'b1);
    rx = 1'b1;
    wait_ticks(2);
    check("break_idle", busy, 1'b0);

    // back-to-back without ack
    wait_ticks(1);
    send_frame(8'h11, 1'b1);
    check("ovr_first_data", rx_data, 8'h11);
    check("ovr_first_flag", overrun, 1'b0);
    send_frame(8'h22, 1'b1);
    check("ovr_data", rx_data, 8'h22);
    check("ovr_valid", rx_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    pulse_ack();
    check("ovr_ack_valid", rx_valid, 1'b0);
    check("ovr_ack_flag", overrun, 1'b0);

    // ack lands on the exact delivery edge of the second byte
    wait_ticks(1);
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        repeat (16 + 152 * 16 - 1) @(posedge clk);
        #1 rx_ack = 1'b1;
        @(posedge clk);
        #1 rx_ack = 1'b0;
      end
    join
    check("same_ack_valid", rx_valid, 1'b1);
    check("same_ack_overrun", overrun, 1'b0);
    check("same_ack_data", rx_data, 8'h22);

    reset_mid_frame();
    pulse_ack();

    // tick every clk: detection 3 edges after the fall (synchronizer), valid 152 edges later
    tick_div = 1;
    send_timed(8'hA5, 3 + 152);
    reset_mid_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
